zx_io_ports: RTL and testbench

// - Z80 OUT-port write decoder for the ZX Spectrum 128 core; sits between the Z80 bus and the

---
 rtl/zx_io_pkg.sv | 20 ++
 rtl/zx_sigma_delta.sv | 30 +++
 rtl/zx_io_ports.sv | 117 +++++++++++
 tb/tb_zx_io_ports.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_io_pkg.sv
// Shared constants and types for the ZX Spectrum 128 OUT-port decoder.
// Port addresses, the paging lock bit, FSM state encoding and default audio levels.
package zx_io_pkg;

    localparam logic [15:0] PORT_7FFD   = 16'h7FFD;
    localparam logic [7:0]  PORT_FE     = 8'hFE;
    localparam int          MB_LOCK_BIT = 5;

    localparam int DEF_ACC_BITS  = 10;
    localparam int DEF_LEVEL_EAR = 640;
    localparam int DEF_LEVEL_MIC = 96;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        COMMIT   = 2'd2,
        WAIT_END = 2'd3
    } io_state_t;

endpackage

// File: rtl/zx_sigma_delta.sv
// First-order sigma-delta modulator: the carry out of a free-running accumulator
// gives a 1-bit stream whose mean density is level / 2^ACC_BITS.
module zx_sigma_delta #(
    parameter int ACC_BITS = 10
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [ACC_BITS-1:0] i_level,
    output logic                o_bit
);

    logic [ACC_BITS-1:0] r_acc;
    logic                r_bit;
    logic [ACC_BITS:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_level};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_acc <= '0;
            r_bit <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_BITS-1:0];
            r_bit <= w_sum[ACC_BITS];
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/zx_io_ports.sv
// Z80 OUT-port write decoder: captures 7FFD (paging) and FE (border/MIC/beeper)
// writes into the clock_25 domain and produces the sigma-delta audio bit.
module zx_io_ports
    import zx_io_pkg::*;
#(
    parameter bit                  FULL_DECODE = 1'b0,
    parameter int                  ACC_BITS    = DEF_ACC_BITS,
    parameter logic [ACC_BITS-1:0] LEVEL_EAR   = ACC_BITS'(DEF_LEVEL_EAR),
    parameter logic [ACC_BITS-1:0] LEVEL_MIC   = ACC_BITS'(DEF_LEVEL_MIC)
) (
    input  logic        clock_25,
    input  logic        RESET_N,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic [7:0]  membank,
    output logic [2:0]  border,
    output logic        mic,
    output logic        beeper,
    output logic        audio_out,
    output logic        wr_commit,
    output io_state_t   o_dbg_state
);

    logic            w_iow;
    logic            r_iow_meta;
    logic            r_iow_s;
    io_state_t       r_state;
    io_state_t       w_state_next;
    logic            w_commit;
    logic            w_hit_7ffd;
    logic            w_hit_fe;
    logic [7:0]      r_membank;
    logic [2:0]      r_border;
    logic            r_mic;
    logic            r_beeper;
    logic            r_wr_commit;
    logic [ACC_BITS:0]   w_level_sum;
    logic [ACC_BITS-1:0] w_level;

    // INTA (nM1=0 with nIORQ=0) and reads must never look like a write.
    assign w_iow = !nIORQ && !nWR && nRD && nM1;

    // Synchroniser is left out of reset so a strobe held across reset release stays visible.
    always_ff @(posedge clock_25) begin
        r_iow_meta <= w_iow;
        r_iow_s    <= r_iow_meta;
    end

    // One commit per IO cycle: the strobe must be seen twice (IDLE->QUAL->COMMIT) and then
    // drop (WAIT_END) before another write is accepted; A/D are sampled only in COMMIT.
    always_ff @(posedge clock_25) begin
        if (!RESET_N) r_state <= WAIT_END;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (r_iow_s) w_state_next = QUAL;
            QUAL:     w_state_next = r_iow_s ? COMMIT : IDLE;
            COMMIT:   w_state_next = WAIT_END;
            WAIT_END: if (!r_iow_s) w_state_next = IDLE;
            default:  w_state_next = WAIT_END;
        endcase
    end

    assign w_commit = (r_state == COMMIT);

    assign w_hit_7ffd = FULL_DECODE ? (A == PORT_7FFD) : (!A[15] && !A[1]);
    assign w_hit_fe   = FULL_DECODE ? (A[7:0] == PORT_FE) : !A[0];

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            r_membank   <= '0;
            r_border    <= '0;
            r_mic       <= 1'b0;
            r_beeper    <= 1'b0;
            r_wr_commit <= 1'b0;
        end else begin
            r_wr_commit <= w_commit;
            if (w_commit) begin
                // Once the lock bit is set, paging is frozen until the next reset.
                if (w_hit_7ffd && !r_membank[MB_LOCK_BIT]) r_membank <= D;
                if (w_hit_fe) begin
                    r_border <= D[2:0];
                    r_mic    <= D[3];
                    r_beeper <= D[4];
                end
            end
        end
    end

    assign w_level_sum = (r_beeper ? {1'b0, LEVEL_EAR} : '0)
                       + (r_mic    ? {1'b0, LEVEL_MIC} : '0);
    assign w_level     = w_level_sum[ACC_BITS] ? '1 : w_level_sum[ACC_BITS-1:0];

    zx_sigma_delta #(
        .ACC_BITS (ACC_BITS)
    ) u_sigma_delta (
        .i_clk     (clock_25),
        .i_reset_n (RESET_N),
        .i_level   (w_level),
        .o_bit     (audio_out)
    );

    assign membank     = r_membank;
    assign border      = r_border;
    assign mic         = r_mic;
    assign beeper      = r_beeper;
    assign wr_commit   = r_wr_commit;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_zx_io_ports.sv
// Directed bench for zx_io_ports: partial-decode and full-decode instances share one bus;
// committed writes are predicted into a queue and checked when wr_commit pulses.
module tb_zx_io_ports;
    import zx_io_pkg::*;

    logic        clock_25;
    logic        RESET_N;
    logic [15:0] A;
    logic [7:0]  D;
    logic        nIORQ, nRD, nWR, nM1;

    logic [7:0]  mb0, mb1;
    logic [2:0]  bd0, bd1;
    logic        mic0, mic1, bp0, bp1, au0, au1, wc0, wc1;
    io_state_t   st0, st1;

    int errors = 0;
    int checks = 0;
    int cc0 = 0;
    int cc1 = 0;

    logic [25:0] exp_q[$];
    logic [7:0]  m_mb[2];
    logic [2:0]  m_bd[2];
    logic        m_mic[2];
    logic        m_bp[2];

    zx_io_ports #(.FULL_DECODE(1'b0)) dut0 (
        .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D),
        .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
        .membank(mb0), .border(bd0), .mic(mic0), .beeper(bp0),
        .audio_out(au0), .wr_commit(wc0), .o_dbg_state(st0)
    );

    zx_io_ports #(.FULL_DECODE(1'b1)) dut1 (
        .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D),
        .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
        .membank(mb1), .border(bd1), .mic(mic1), .beeper(bp1),
        .audio_out(au1), .wr_commit(wc1), .o_dbg_state(st1)
    );

    // clock / reset
    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    always @(negedge clock_25) begin
        if (wc0 === 1'b1) cc0++;
        if (wc1 === 1'b1) cc1++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // reference model
    function automatic bit hit7(input bit full, input logic [15:0] a);
        return full ? (a == 16'h7FFD) : (!a[15] && !a[1]);
    endfunction

    function automatic bit hitfe(input bit full, input logic [15:0] a);
        return full ? (a[7:0] == 8'hFE) : !a[0];
    endfunction

    task automatic model_apply(input int i, input logic [15:0] a, input logic [7:0] d);
        if (hit7(i == 1, a) && !m_mb[i][5]) m_mb[i] = d;
        if (hitfe(i == 1, a)) begin
            m_bd[i]  = d[2:0];
            m_mic[i] = d[3];
            m_bp[i]  = d[4];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mb[i] = '0; m_bd[i] = '0; m_mic[i] = 1'b0; m_bp[i] = 1'b0;
        end
    endtask

    function automatic logic [25:0] pack_model();
        return {m_mb[0], m_bd[0], m_mic[0], m_bp[0], m_mb[1], m_bd[1], m_mic[1], m_bp[1]};
    endfunction

    task automatic chk_expected(input logic [25:0] e);
        chk("sb_membank0", mb0, e[25:18]);
        chk("sb_border0",  bd0, e[17:15]);
        chk("sb_mic0",     mic0, e[14]);
        chk("sb_beeper0",  bp0, e[13]);
        chk("sb_membank1", mb1, e[12:5]);
        chk("sb_border1",  bd1, e[4:2]);
        chk("sb_mic1",     mic1, e[1]);
        chk("sb_beeper1",  bp1, e[0]);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_membank0"}, mb0, m_mb[0]);
        chk({tag, "_border0"},  bd0, m_bd[0]);
        chk({tag, "_mic0"},     mic0, m_mic[0]);
        chk({tag, "_beeper0"},  bp0, m_bp[0]);
        chk({tag, "_membank1"}, mb1, m_mb[1]);
        chk({tag, "_border1"},  bd1, m_bd[1]);
        chk({tag, "_mic1"},     mic1, m_mic[1]);
        chk({tag, "_beeper1"},  bp1, m_bp[1]);
    endtask

    task automatic bus_idle();
        nIORQ = 1'b1; nWR = 1'b1; nRD = 1'b1; nM1 = 1'b1;
    endtask

    // driver: one IO cycle with nWR low for len clocks; nRD/nM1 chosen by caller
    task automatic io_cycle(input string tag, input logic [15:0] addr, input logic [7:0] data,
                            input int len, input logic rd_n, input logic m1_n,
                            input bit expect_commit);
        int c0, c1, seen;
        logic [25:0] e;
        seen = 0;
        @(posedge clock_25); #1;
        c0 = cc0; c1 = cc1;
        if (expect_commit) begin
            model_apply(0, addr, data);
            model_apply(1, addr, data);
            exp_q.push_back(pack_model());
        end
        A = addr; D = data; nIORQ = 1'b0; nWR = 1'b0; nRD = rd_n; nM1 = m1_n;
        for (int cyc = 1; cyc <= len + 8; cyc++) begin
            @(negedge clock_25);
            if (wc0 === 1'b1 && seen == 0 && exp_q.size() > 0) begin
                seen = cyc;
                e = exp_q.pop_front();
                chk_expected(e);
                chk_rng({tag, "_latency"}, cyc - 1, 4, 5);
            end
            if (cyc == len) begin
                @(posedge clock_25); #1;
                bus_idle();
            end
        end
        if (expect_commit) begin
            chk({tag, "_commit_seen"}, 16'(seen != 0), 16'd1);
            if (seen == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        chk({tag, "_commits0"}, 16'(cc0 - c0), 16'(expect_commit));
        chk({tag, "_commits1"}, 16'(cc1 - c1), 16'(expect_commit));
        chk_regs(tag);
    endtask

    task automatic count_audio(input int n, output int n0, output int n1);
        n0 = 0; n1 = 0;
        repeat (n) begin
            @(negedge clock_25);
            n0 += int'(au0);
            n1 += int'(au1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out0"}, {mb0, bd0, mic0, bp0, au0, wc0}, 16'd0);
        chk({tag, "_out1"}, {mb1, bd1, mic1, bp1, au1, wc1}, 16'd0);
    endtask

    initial begin
        int n0, n1, c0, c1;
        bit found;
        A = 16'h0000; D = 8'h00;
        bus_idle();
        RESET_N = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clock_25);
        @(negedge clock_25);
        chk_all_zero("reset");
        chk("reset_state0", 16'(st0), 16'(WAIT_END));
        chk("reset_state1", 16'(st1), 16'(WAIT_END));
        @(posedge clock_25); #1;
        RESET_N = 1'b1;
        repeat (3) @(negedge clock_25);
        chk("idle_state0", 16'(st0), 16'(IDLE));

        // paging write, 6-cycle strobe
        io_cycle("out7ffd_17", 16'h7FFD, 8'h17, 6, 1'b1, 1'b1, 1'b1);

        // border/beeper write and audio density
        io_cycle("outfe_15", 16'h00FE, 8'h15, 8, 1'b1, 1'b1, 1'b1);
        count_audio(1024, n0, n1);
        chk_rng("audio_beeper0", n0, 639, 641);
        chk_rng("audio_beeper1", n1, 639, 641);

        io_cycle("outfe_1a", 16'h12FE, 8'h1A, 10, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clock_25);
        count_audio(1024, n0, n1);
        chk_rng("audio_both0", n0, 735, 737);
        chk_rng("audio_both1", n1, 735, 737);

        // rejected cycles: glitch, INTA with nWR low, read with nWR low
        io_cycle("glitch", 16'h7FFD, 8'hAA, 1, 1'b1, 1'b1, 1'b0);
        io_cycle("inta",   16'h00FE, 8'h07, 8, 1'b1, 1'b0, 1'b0);
        io_cycle("read",   16'h7FFD, 8'h55, 8, 1'b0, 1'b1, 1'b0);

        // partial decode hits both ports; full decode hits neither
        io_cycle("out7ffc_03", 16'h7FFC, 8'h03, 6, 1'b1, 1'b1, 1'b1);

        // long strobe still commits once; lock bit then freezes paging
        io_cycle("lock_20", 16'h7FFD, 8'h20, 20, 1'b1, 1'b1, 1'b1);
        io_cycle("locked_07", 16'h7FFD, 8'h07, 6, 1'b1, 1'b1, 1'b1);
        chk("locked_membank0", mb0, 8'h20);

        // reset pulse clears the lock
        @(posedge clock_25); #1;
        RESET_N = 1'b0;
        @(posedge clock_25); #1;
        RESET_N = 1'b1;
        model_reset();
        @(negedge clock_25);
        chk_all_zero("reset_pulse");
        io_cycle("unlock_07", 16'h7FFD, 8'h07, 6, 1'b1, 1'b1, 1'b1);
        chk("unlock_membank1", mb1, 8'h07);

        // reset during COMMIT; the write still active after release is discarded
        @(posedge clock_25); #1;
        c0 = cc0; c1 = cc1;
        A = 16'h00FE; D = 8'h1F; nIORQ = 1'b0; nWR = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock_25);
            if (st0 == COMMIT) found = 1'b1;
        end
        chk("rst_commit_reached", 16'(found), 16'd1);
        RESET_N = 1'b0;
        @(negedge clock_25);
        chk_all_zero("rst_in_commit");
        chk("rst_in_commit_state0", 16'(st0), 16'(WAIT_END));
        @(posedge clock_25); #1;
        RESET_N = 1'b1;
        model_reset();
        repeat (6) @(negedge clock_25);
        chk("rst_held_state0", 16'(st0), 16'(WAIT_END));
        @(posedge clock_25); #1;
        bus_idle();
        repeat (8) @(negedge clock_25);
        chk("rst_commits0", 16'(cc0 - c0), 16'd0);
        chk("rst_commits1", 16'(cc1 - c1), 16'd0);
        chk_regs("after_rst_write");
        count_audio(64, n0, n1);
        chk("audio_silent0", 16'(n0), 16'd0);
        chk("audio_silent1", 16'(n1), 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
